// File: rtl/fifo_sample_reader.sv
// fifo_sample_reader: paces FIFO samples out to a serial DAC, one word per sample tick.
//   Optional feature macro: READER_UNDERRUN_HOLD_EN (an underrun tick resends the last word).
//   Ports: clk, rst (async, active low); en_i streaming enable; empty_i / rd_data_i / rd_en_o
//   FIFO read side (data valid one cycle after rd_en_o); sclk_o / cs_n_o / mosi_o DAC serial
//   link (MSB first, DAC samples on sclk rise); busy_o frame in progress; underrun_o sticky.
module fifo_sample_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int INT_BITS   = 4,
  parameter int DAC_BITS   = 16,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rd_en_o,
  output logic                  sclk_o,
  output logic                  cs_n_o,
  output logic                  mosi_o,
  output logic                  busy_o,
  output logic                  underrun_o
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DAC_BITS + 1);
  localparam logic [DAC_BITS-1:0] MID = {1'b1, {(DAC_BITS-1){1'b0}}};

  if (SAMPLE_DIV < 2 + 2*CLK_DIV*DAC_BITS + CLK_DIV || CLK_DIV < 1 || DAC_BITS > DATA_WIDTH
      || INT_BITS < 1 || INT_BITS > DATA_WIDTH) begin : g_bad_cfg
    $error("fifo_sample_reader: inconsistent parameters");
  end

  typedef enum logic [2:0] {IDLE, POP, LATCH, SHIFT, GAP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                phase_q, phase_d;
  logic                under_q, under_d;
  logic [DAC_BITS-1:0] shift_q, shift_d;
  logic [DAC_BITS-1:0] last_q, last_d;
  logic                tick, div_end;
  logic                unused_bits;

  // Only the top DAC_BITS of the FIFO word reach the DAC.
  assign unused_bits = ^rd_data_i;
  assign tick        = en_i && cnt_q == CW'(SAMPLE_DIV - 1);
  assign div_end     = div_q == DW'(CLK_DIV - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = en_i ? (tick ? '0 : cnt_q + 1'b1) : '0;
    div_d      = div_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    last_d     = last_q;
    under_d    = en_i && (under_q || (tick && state_q == IDLE && empty_i));
    rd_en_o    = state_q == POP && !empty_i;
    sclk_o     = state_q == SHIFT && phase_q;
    cs_n_o     = state_q != SHIFT;
    mosi_o     = state_q == SHIFT && shift_q[DAC_BITS-1];
    busy_o     = state_q != IDLE;
    underrun_o = under_q;
    case (state_q)
      IDLE: begin
        if (tick && !empty_i) state_d = POP;
`ifdef READER_UNDERRUN_HOLD_EN
        else if (tick) begin
          state_d = SHIFT;
          shift_d = last_q;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end
`endif
      end
      POP: state_d = LATCH;
      LATCH: begin
        // Flipping the sign bit maps two's complement onto offset binary.
        shift_d = rd_data_i[DATA_WIDTH-1 -: DAC_BITS] ^ MID;
        last_d  = rd_data_i[DATA_WIDTH-1 -: DAC_BITS] ^ MID;
        div_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          phase_d = !phase_q;
          // Advance to the next bit only after the high half, so mosi is stable across the rise.
          if (phase_q) begin
            shift_d = shift_q << 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BW'(DAC_BITS - 1)) state_d = GAP;
          end
        end
      end
      GAP: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      under_q <= 1'b0;
      shift_q <= '0;
      last_q  <= MID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      under_q <= under_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_fifo_sample_reader.sv
// tb_fifo_sample_reader: scoreboard bench for fifo_sample_reader with a behavioural FIFO.
module tb_fifo_sample_reader;
  logic        clk = 1'b0, rst = 1'b0, en_i = 1'b0, empty_i = 1'b1;
  logic [31:0] rd_data_i = '0;
  logic        rd_en_o, sclk_o, cs_n_o, mosi_o, busy_o, underrun_o;

  always #5 clk = ~clk;

  fifo_sample_reader dut (
    .clk(clk), .rst(rst), .en_i(en_i), .empty_i(empty_i), .rd_data_i(rd_data_i),
    .rd_en_o(rd_en_o), .sclk_o(sclk_o), .cs_n_o(cs_n_o), .mosi_o(mosi_o),
    .busy_o(busy_o), .underrun_o(underrun_o)
  );

  int          n_checks = 0, n_errors = 0;
  logic [31:0] fifo[$];
  logic [15:0] exp_q[$];
  int          starts[$];
  int          cyc = 0, n_rd = 0, n_frames = 0, bits = 0, cs_cnt = 0, busy_cnt = 0;
  logic        in_frame = 1'b0, popped = 1'b0, prev_sclk = 1'b0;
  logic [15:0] word = '0;
  int          r0, f0, s0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] dac(input logic [31:0] w);
    return w[31:16] ^ 16'h8000;
  endfunction

  // FIFO model: pop seen during a cycle returns data just after the following edge.
  initial begin
    logic pend;
    forever begin
      @(negedge clk);
      pend = rd_en_o;
      @(posedge clk);
      #1;
      if (pend) begin
        check("pop_nonempty", fifo.size() == 0, 0);
        if (fifo.size() != 0) begin
          rd_data_i = fifo.pop_front();
          exp_q.push_back(dac(rd_data_i));
        end
      end
      empty_i = fifo.size() == 0;
    end
  end

  // Monitor: rebuild each DAC word from sclk rises and score it.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      in_frame = 1'b0; bits = 0; cs_cnt = 0; busy_cnt = 0; popped = 1'b0; prev_sclk = 1'b0;
    end else begin
      if (rd_en_o) begin n_rd++; popped = 1'b1; end
      if (busy_o) busy_cnt++;
      else if (busy_cnt != 0) begin
        check("busy_len", busy_cnt, popped ? 134 : 132);
        busy_cnt = 0;
        popped = 1'b0;
      end
      if (!cs_n_o) begin
        if (!in_frame) begin in_frame = 1'b1; bits = 0; word = '0; starts.push_back(cyc); end
        cs_cnt++;
        if (sclk_o && !prev_sclk) begin word = {word[14:0], mosi_o}; bits++; end
      end else if (in_frame) begin
        in_frame = 1'b0;
        check("frame_bits", bits, 16);
        check("cs_low_len", cs_cnt, 128);
        check("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("word", word, exp_q.pop_front());
        n_frames++;
        cs_cnt = 0;
      end
      prev_sclk = sclk_o;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int t0 = n_frames;
    for (int i = 0; i < budget && n_frames < t0 + n; i++) @(negedge clk);
    check("frame_wait", n_frames - t0, n);
  endtask

  task automatic wait_bits(input int k, input int budget);
    for (int i = 0; i < budget && !(in_frame && bits >= k); i++) @(negedge clk);
    check("bit_wait", in_frame && bits >= k, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_sclk", sclk_o, 0);
    check("rst_cs_n", cs_n_o, 1);
    check("rst_mosi", mosi_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_underrun", underrun_o, 0);
    rst = 1'b1;
    // Single frame
    fifo.push_back(32'h4000_0000);
    r0 = n_rd;
    en_i = 1'b1;
    wait_frames(1, 600);
    repeat (10) @(negedge clk);
    check("t1_rd_pulses", n_rd - r0, 1);
    check("t1_underrun", underrun_o, 0);
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    // Three boundary words, frames one sample period apart
    fifo.push_back(32'h8000_0000);
    fifo.push_back(32'h0000_0000);
    fifo.push_back(32'h7FFF_FFFF);
    s0 = starts.size();
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    wait_frames(3, 1200);
    check("t2_underrun", underrun_o, 0);
    en_i = 1'b0;
    check("t2_period_a", starts[s0+1] - starts[s0], 256);
    check("t2_period_b", starts[s0+2] - starts[s0+1], 256);
    repeat (10) @(negedge clk);
    // Underrun on an empty FIFO
    r0 = n_rd;
    f0 = n_frames;
`ifdef READER_UNDERRUN_HOLD_EN
    exp_q.push_back(16'hFFFF);
`endif
    en_i = 1'b1;
    repeat (400) @(negedge clk);
    check("t3_underrun_set", underrun_o, 1);
    check("t3_no_pop", n_rd - r0, 0);
`ifdef READER_UNDERRUN_HOLD_EN
    check("t3_frames", n_frames - f0, 1);
`else
    check("t3_frames", n_frames - f0, 0);
`endif
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_underrun_clr", underrun_o, 0);
    // Enable dropped at bit 5
    fifo.push_back(32'h1234_5678);
    r0 = n_rd;
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    wait_bits(5, 600);
    en_i = 1'b0;
    wait_frames(1, 400);
    repeat (300) @(negedge clk);
    check("t4_rd_pulses", n_rd - r0, 1);
    check("t4_counter", dut.cnt_q, 0);
    check("t4_busy", busy_o, 0);
    // Reset at bit 8
    fifo.push_back(32'h2000_0000);
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    wait_bits(8, 600);
    rst = 1'b0;
    #1;
    check("t5_cs_n", cs_n_o, 1);
    check("t5_sclk", sclk_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_mosi", mosi_o, 0);
    exp_q.delete();
    fifo.push_back(32'h6000_0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_frames(1, 600);
    repeat (10) @(negedge clk);
    check("t5_sb_drained", exp_q.size(), 0);
    check("t5_fifo_drained", fifo.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
